// File: rtl/div_pkg.sv
// Shared types for the shift/subtract divider: FSM state encoding and
// the iteration-counter width helper.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } div_state_t;

    localparam int DEF_WIDTH = 8;

    // Counter must hold 0..WIDTH-1 with headroom up to WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/shift_sub_divider_if.sv
// Switch/result bundle of the divider, with a master (operator side)
// and slave (divider side) view.
interface shift_sub_divider_if
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             run;
    logic             clear_loadb;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (output run, clear_loadb, s,
                    input  q, r, b, busy, done, div_zero);
    modport slave  (input  run, clear_loadb, s,
                    output q, r, b, busy, done, div_zero);
endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on the {A,Q} register pair.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   a_next,
    output logic [WIDTH-1:0] q_next
);
    logic [WIDTH+1:0] shifted;
    logic             ge;

    always_comb begin
        shifted = {a, q[WIDTH-1]};
        ge      = shifted >= {2'b00, b};
        a_next  = ge ? (WIDTH+1)'(shifted - {2'b00, b}) : shifted[WIDTH:0];
        q_next  = {q[WIDTH-2:0], ge};
    end
endmodule

// File: rtl/shift_sub_divider.sv
// Sequential restoring divider, one quotient bit per cycle.
// Define DIV_SIGNED_EN for two's-complement operands (truncating toward zero).
module shift_sub_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Run,
    input  logic             Clear_LoadB,
    input  logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero
);
    localparam int CNT_W = cnt_width(WIDTH);

    div_state_t       state, state_nxt;
    logic [WIDTH:0]   a_reg;
    logic [CNT_W-1:0] cnt;
    logic             load, start, last_step;
    logic [WIDTH-1:0] s_mag, b_op;
    logic [WIDTH:0]   a_step;
    logic [WIDTH-1:0] q_step;

`ifdef DIV_SIGNED_EN
    logic q_neg, r_neg;
    assign s_mag = S[WIDTH-1] ? -S : S;
    assign b_op  = B[WIDTH-1] ? -B : B;
`else
    assign s_mag = S;
    assign b_op  = B;
`endif

    assign Busy = (state == CALC) || (state == FIXUP);

    div_step #(.WIDTH(WIDTH)) u_step (
        .a      (a_reg),
        .q      (Q),
        .b      (b_op),
        .a_next (a_step),
        .q_next (q_step)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        start     = 1'b0;
        last_step = (cnt == CNT_W'(WIDTH - 1));
        case (state)
            IDLE: begin
                load  = Clear_LoadB;
                start = !Clear_LoadB && Run;
                if (start) state_nxt = (B == '0) ? DONE : CALC;
            end
            CALC:    if (last_step) state_nxt = FIXUP;
            FIXUP:   state_nxt = DONE;
            DONE:    if (!Run) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Q       <= '0;
            R       <= '0;
            B       <= '0;
            a_reg   <= '0;
            cnt     <= '0;
            Done    <= 1'b0;
            DivZero <= 1'b0;
`ifdef DIV_SIGNED_EN
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
`endif
        end else if (load) begin
            B       <= S;
            Q       <= '0;
            R       <= '0;
            Done    <= 1'b0;
            DivZero <= 1'b0;
        end else if (start) begin
            a_reg   <= '0;
            cnt     <= '0;
            DivZero <= (B == '0);
            // Zero divisor bypasses CALC: saturated quotient, raw dividend as remainder.
            if (B == '0) begin
                Q    <= '1;
                R    <= S;
                Done <= 1'b1;
            end else begin
                Q    <= s_mag;
                Done <= 1'b0;
            end
`ifdef DIV_SIGNED_EN
            q_neg <= S[WIDTH-1] ^ B[WIDTH-1];
            r_neg <= S[WIDTH-1];
`endif
        end else if (state == CALC) begin
            a_reg <= a_step;
            Q     <= q_step;
            cnt   <= cnt + CNT_W'(1);
        end else if (state == FIXUP) begin
            Done <= 1'b1;
`ifdef DIV_SIGNED_EN
            R <= r_neg ? -a_reg[WIDTH-1:0] : a_reg[WIDTH-1:0];
            Q <= q_neg ? -Q : Q;
`else
            R <= a_reg[WIDTH-1:0];
`endif
        end
    end
endmodule

// File: tb/tb_shift_sub_divider.sv
// Scoreboard bench for shift_sub_divider: driver pushes reference results,
// monitor pops and compares on every Done rising edge.
module tb_shift_sub_divider;
    import div_pkg::*;

    localparam int W = 8;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;

    shift_sub_divider_if #(.WIDTH(W)) dif();

    shift_sub_divider #(.WIDTH(W)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Run         (dif.run),
        .Clear_LoadB (dif.clear_loadb),
        .S           (dif.s),
        .Q           (dif.q),
        .R           (dif.r),
        .B           (dif.b),
        .Busy        (dif.busy),
        .Done        (dif.done),
        .DivZero     (dif.div_zero)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           lat;
        int           busy_cyc;
        int           start_cyc;
    } exp_t;

    exp_t         exp_q[$];
    int           cyc = 0;
    int           tests = 0;
    int           fails = 0;
    int           busy_cnt = 0;
    logic         done_q = 1'b0;
    logic [W-1:0] cur_dvs = '0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    // Reference: plain integer division from the operand values.
    function automatic exp_t model(input logic [W-1:0] dvs, input logic [W-1:0] dvd);
        exp_t e;
        e.start_cyc = 0;
        if (dvs == '0) begin
            e.q = '1; e.r = dvd; e.dz = 1'b1; e.lat = 1; e.busy_cyc = 0;
        end else begin
`ifdef DIV_SIGNED_EN
            int sa, sb;
            sa = $signed(dvd);
            sb = $signed(dvs);
            e.q = W'(sa / sb);
            e.r = W'(sa % sb);
`else
            e.q = dvd / dvs;
            e.r = dvd % dvs;
`endif
            e.dz = 1'b0; e.lat = W + 2; e.busy_cyc = W + 1;
        end
        return e;
    endfunction

    always @(negedge Clk) begin
        exp_t e;
        if (!Reset_n) begin
            busy_cnt = 0;
            done_q   = 1'b0;
        end else begin
            if (dif.busy) busy_cnt++;
            check("busy_done_excl", {31'd0, dif.busy & dif.done}, 32'd0);
            if (dif.done && !done_q) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_done: got Done rise at cycle %0d, expected none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("quotient",  dif.q, e.q);
                    check("remainder", dif.r, e.r);
                    check("divzero",   dif.div_zero, e.dz);
                    check("latency",   cyc - e.start_cyc, e.lat);
                    check("busy_cycles", busy_cnt, e.busy_cyc);
                end
                busy_cnt = 0;
            end
            done_q = dif.done;
        end
    end

    task automatic load(input logic [W-1:0] d);
        @(negedge Clk);
        dif.clear_loadb = 1'b1;
        dif.s = d;
        @(negedge Clk);
        dif.clear_loadb = 1'b0;
        cur_dvs = d;
        check("load_b", dif.b, d);
        check("load_done_clr", dif.done, 0);
    endtask

    task automatic start(input logic [W-1:0] dvd, input logic hold, output exp_t e);
        @(negedge Clk);
        e = model(cur_dvs, dvd);
        e.start_cyc = cyc;
        exp_q.push_back(e);
        dif.s = dvd;
        dif.run = 1'b1;
        @(negedge Clk);
        if (!hold) dif.run = 1'b0;
        dif.s = W'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!dif.done && n < 100) begin
            @(negedge Clk);
            n++;
        end
        check("done_timeout", dif.done, 1);
    endtask

    task automatic divide(input logic [W-1:0] dvs, input logic [W-1:0] dvd);
        exp_t e;
        load(dvs);
        start(dvd, 1'b0, e);
        wait_done();
        @(negedge Clk);
    endtask

    initial begin
        exp_t e;
        dif.run = 1'b0;
        dif.clear_loadb = 1'b0;
        dif.s = '0;
        repeat (2) @(negedge Clk);
        check("rst_q", dif.q, 0);
        check("rst_r", dif.r, 0);
        check("rst_b", dif.b, 0);
        check("rst_flags", {dif.busy, dif.done, dif.div_zero}, 0);
        Reset_n = 1'b1;

        // Directed cases, including retention of the result after Run drops.
        load(8'd7);
        start(8'd100, 1'b0, e);
        wait_done();
        repeat (5) @(negedge Clk);
        check("hold_done", dif.done, 1);
        check("hold_q", dif.q, e.q);
        check("hold_r", dif.r, e.r);
        divide(8'd9, 8'd7);
        divide(8'd1, 8'd255);
        divide(8'd0, 8'd5);
`ifdef DIV_SIGNED_EN
        divide(8'd7, 8'h9C);
        divide(8'hF9, 8'd100);
        divide(8'hFF, 8'h80);
`endif

        // Reset in the middle of CALC.
        load(8'd7);
        start(8'd100, 1'b0, e);
        repeat (3) @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        check("mid_rst_q", dif.q, 0);
        check("mid_rst_r", dif.r, 0);
        check("mid_rst_b", dif.b, 0);
        check("mid_rst_flags", {dif.busy, dif.done, dif.div_zero}, 0);
        exp_q.delete();
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        divide(8'd7, 8'd100);

        // Clear_LoadB during CALC is ignored; Run held through DONE does not retrigger.
        load(8'd7);
        start(8'd100, 1'b1, e);
        @(negedge Clk);
        dif.clear_loadb = 1'b1;
        dif.s = 8'd3;
        repeat (2) @(negedge Clk);
        dif.clear_loadb = 1'b0;
        check("calc_b_kept", dif.b, 7);
        wait_done();
        repeat (4) @(negedge Clk);
        check("run_hold_done", dif.done, 1);
        check("run_hold_busy", dif.busy, 0);
        dif.run = 1'b0;
        repeat (2) @(negedge Clk);

        // Randomized operands, occasional zero divisor.
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] dvs;
            dvs = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom);
            divide(dvs, W'($urandom));
        end

        repeat (3) @(negedge Clk);
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
